axi4_burst_mem: RTL
===================

AXI4_BURST_MEM -- requirements
Module: axi4_burst_mem

Interface
REQ-001 Parameter DATA_W, default 32, data bus width in bits (32 or 64).
REQ-002 Parameter DEPTH, default 256, memory depth in DATA_W words (power of two).
REQ-003 Parameter BASE_ADDR, default 32'h1000_0000, byte address of word 0.
REQ-004 PCLK  in  1  single clock, all logic rising-edge.
REQ-005 PRESETn  in  1  asynchronous active-low reset.
REQ-006 araddr/arvalid/arready/arsize/arlen/arburst  in,in,out,in,in,in  32,1,1,3,8,2  AXI4 read address channel.
REQ-007 rdata/rvalid/rready/rlast/rresp  out,out,in,out,out  DATA_W,1,1,1,2  AXI4 read data channel.
REQ-008 awaddr/awvalid/awready/awsize/awlen/awburst  in,in,out,in,in,in  32,1,1,3,8,2  AXI4 write address channel.
REQ-009 wdata/wvalid/wready/wstrb/wlast  in,in,out,in,in  DATA_W,1,1,DATA_W/8,1  AXI4 write data channel.
REQ-010 bvalid/bready/bresp  out,in,out  1,1,2  AXI4 write response channel.

Function
REQ-011 Read and write paths shall be independent FSMs, running concurrently on a dual-port byte-writable array.
REQ-012 Write FSM states W_IDLE, W_DATA, W_RESP; awready=1 only in W_IDLE; AW handshake -> W_DATA next cycle.
REQ-013 W_DATA: wready=1; each wvalid beat writes the bytes enabled by wstrb at the current address; beat counter increments.
REQ-014 On beat awlen+1 -> W_RESP; wlast on any other beat, or absent on that beat, shall set bresp SLVERR (2'b10); burst still ends at beat awlen+1.
REQ-015 W_RESP: bvalid=1 held until bready; handshake -> W_IDLE; bvalid and bresp stable while stalled.
REQ-016 Read FSM states R_IDLE, R_DATA; arready=1 only in R_IDLE; rvalid first asserted the cycle after AR handshake.
REQ-017 R_DATA: rdata/rresp/rlast held stable while rvalid && !rready; advance on rvalid && rready; rlast=1 on beat arlen+1; that handshake -> R_IDLE.
REQ-018 Beat size = 1<<size bytes; size > log2(DATA_W/8) shall make every beat of the burst SLVERR with no array write and rdata=0.
REQ-019 FIXED (2'b00): address constant for all beats.
REQ-020 INCR (2'b01): next = (addr & ~(bytes-1)) + bytes; 32-bit wrap-around permitted, no 4 KB check.
REQ-021 WRAP (2'b10): len in {1,3,7,15} only, else SLVERR for whole burst; span = bytes*(len+1); address wraps to the span-aligned boundary on reaching boundary+span.
REQ-022 Burst type 2'b11 shall give SLVERR for whole burst, no writes.
REQ-023 Beat address outside [BASE_ADDR, BASE_ADDR+DEPTH*DATA_W/8) shall be DECERR (2'b11) for that beat: no write, rdata=0.
REQ-024 Word index = (addr-BASE_ADDR)>>log2(DATA_W/8); byte lanes are not rotated (AXI lane placement is the master's job).
REQ-025 bresp shall report the worst beat response, priority DECERR > SLVERR > OKAY; rresp is per beat.
REQ-026 Same-cycle read and write to one word: read returns pre-write data.
REQ-027 arlen/awlen up to 255 (256 beats) shall be supported.

Reset
REQ-028 PRESETn low shall asynchronously force both FSMs to idle, all output valids to 0, rlast=0, rresp=bresp=2'b00, rdata=0; arready=awready=0 while in reset.
REQ-029 Memory contents shall not be reset; a reset mid-burst shall abort the burst with no response issued afterwards.
REQ-030 arready/awready shall be 1 from the first PCLK edge after PRESETn rises.

Verification
REQ-031 INCR write awaddr=0x1000_0000, awlen=3, awsize=0, wdata 0x78,0x56,0x34,0x12 with wstrb lane-matched (0001,0010,0100,1000) -> bresp OKAY; INCR read of word 0 with arsize=2, arlen=0 -> rdata=0x12345678, rlast=1.
REQ-032 WRAP read araddr=0x1000_0008, arsize=2, arlen=3 -> addresses 0x08,0x0C,0x00,0x04; rlast on beat 4.
REQ-033 Write to 0x2000_0000 -> bresp DECERR, memory unchanged; read there -> rresp DECERR, rdata=0.
REQ-034 Read with rready toggling 1/0 each cycle, arlen=7 -> 8 beats, data stable during stalls, rlast once.
REQ-035 WRAP with awlen=2 -> SLVERR, no writes; wlast on beat 2 of 4 -> SLVERR, 4 beats still accepted.
REQ-036 PRESETn pulsed low mid write burst -> outputs zero immediately; a new AW is accepted the cycle after release.

Source files
------------

// File: rtl/axi4_burst_mem.sv
// AXI4 slave backed by a dual-port byte-writable memory.
// Independent read and write burst engines; FIXED/INCR/WRAP bursts with SLVERR/DECERR reporting.
module axi4_burst_mem #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned DEPTH     = 256,
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000
) (
    input  logic                PCLK,
    input  logic                PRESETn,
    input  logic [31:0]         araddr,
    input  logic                arvalid,
    output logic                arready,
    input  logic [2:0]          arsize,
    input  logic [7:0]          arlen,
    input  logic [1:0]          arburst,
    output logic [DATA_W-1:0]   rdata,
    output logic                rvalid,
    input  logic                rready,
    output logic                rlast,
    output logic [1:0]          rresp,
    input  logic [31:0]         awaddr,
    input  logic                awvalid,
    output logic                awready,
    input  logic [2:0]          awsize,
    input  logic [7:0]          awlen,
    input  logic [1:0]          awburst,
    input  logic [DATA_W-1:0]   wdata,
    input  logic                wvalid,
    output logic                wready,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wlast,
    output logic                bvalid,
    input  logic                bready,
    output logic [1:0]          bresp
);

    localparam int unsigned STRB_W    = DATA_W / 8;
    localparam int unsigned LSB       = $clog2(STRB_W);
    localparam int unsigned AW        = $clog2(DEPTH);
    localparam logic [32:0] MEM_BYTES = 33'(DEPTH * STRB_W);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    function automatic logic burst_err(input logic [2:0] size, input logic [1:0] burst,
                                       input logic [7:0] len);
        logic bad_len;
        bad_len = !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
        return (size > 3'(LSB)) || (burst == 2'b11) || (burst == 2'b10 && bad_len);
    endfunction

    function automatic logic [1:0] beat_resp(input logic [31:0] addr, input logic berr);
        logic [31:0] off;
        off = addr - BASE_ADDR;
        if (berr)
            return RESP_SLVERR;
        if ({1'b0, off} >= MEM_BYTES)
            return RESP_DECERR;
        return RESP_OKAY;
    endfunction

    function automatic logic [AW-1:0] word_idx(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE_ADDR;
        return AW'(off >> LSB);
    endfunction

    function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [2:0] size,
                                              input logic [1:0] burst, input logic [7:0] len);
        logic [31:0] bytes, incr, span, bound;
        bytes = 32'd1 << size;
        incr  = (addr & ~(bytes - 32'd1)) + bytes;
        span  = bytes * ({24'd0, len} + 32'd1);
        bound = addr & ~(span - 32'd1);
        case (burst)
            2'b00:   return addr;
            2'b10:   return (incr == bound + span) ? bound : incr;
            default: return incr;
        endcase
    endfunction

    // DECERR (11) > SLVERR (10) > OKAY (00) matches numeric order
    function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    logic rdy_en;

    // ---------------- write path ----------------
    w_state_t    w_state, w_state_nxt;
    logic [31:0] w_addr;
    logic [2:0]  w_size;
    logic [1:0]  w_burst;
    logic [7:0]  w_len, w_cnt;
    logic        w_berr;
    logic [1:0]  w_resp;
    logic        aw_hs, w_hs, w_final;
    logic [1:0]  w_beat_resp, w_last_resp;
    logic [AW-1:0] w_idx;

    assign awready     = (w_state == W_IDLE) && rdy_en;
    assign wready      = (w_state == W_DATA);
    assign bvalid      = (w_state == W_RESP);
    assign bresp       = bvalid ? w_resp : RESP_OKAY;
    assign aw_hs       = awvalid && awready;
    assign w_hs        = wvalid && wready;
    assign w_final     = (w_cnt == w_len);
    assign w_beat_resp = beat_resp(w_addr, w_berr);
    assign w_last_resp = (wlast != w_final) ? RESP_SLVERR : RESP_OKAY;
    assign w_idx       = word_idx(w_addr);

    always_comb begin
        w_state_nxt = w_state;
        case (w_state)
            W_IDLE:  if (aw_hs) w_state_nxt = W_DATA;
            W_DATA:  if (w_hs && w_final) w_state_nxt = W_RESP;
            W_RESP:  if (bready) w_state_nxt = W_IDLE;
            default: w_state_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rdy_en  <= 1'b0;
            w_addr  <= '0;
            w_size  <= '0;
            w_burst <= '0;
            w_len   <= '0;
            w_cnt   <= '0;
            w_berr  <= 1'b0;
            w_resp  <= RESP_OKAY;
        end else begin
            rdy_en <= 1'b1;
            if (aw_hs) begin
                w_addr  <= awaddr;
                w_size  <= awsize;
                w_burst <= awburst;
                w_len   <= awlen;
                w_cnt   <= '0;
                w_berr  <= burst_err(awsize, awburst, awlen);
                w_resp  <= RESP_OKAY;
            end else if (w_hs) begin
                w_addr <= next_addr(w_addr, w_size, w_burst, w_len);
                w_cnt  <= w_cnt + 8'd1;
                w_resp <= worst(w_resp, worst(w_beat_resp, w_last_resp));
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (w_hs && w_beat_resp == RESP_OKAY) begin
            for (int unsigned b = 0; b < STRB_W; b++) begin
                if (wstrb[b])
                    mem[w_idx][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    // ---------------- read path ----------------
    r_state_t    r_state, r_state_nxt;
    logic [31:0] r_addr;
    logic [2:0]  r_size;
    logic [1:0]  r_burst;
    logic [7:0]  r_len, r_cnt;
    logic        r_berr;
    logic        ar_hs, r_hs, r_final, r_load;
    logic [31:0] ld_addr;
    logic        ld_berr;
    logic [1:0]  ld_resp;
    logic [AW-1:0] ld_idx;

    assign arready = (r_state == R_IDLE) && rdy_en;
    assign rvalid  = (r_state == R_DATA);
    assign ar_hs   = arvalid && arready;
    assign r_hs    = rvalid && rready;
    assign r_final = (r_cnt == r_len);
    assign rlast   = rvalid && r_final;
    assign r_load  = ar_hs || (r_hs && !r_final);
    assign ld_addr = ar_hs ? araddr : next_addr(r_addr, r_size, r_burst, r_len);
    assign ld_berr = ar_hs ? burst_err(arsize, arburst, arlen) : r_berr;
    assign ld_resp = beat_resp(ld_addr, ld_berr);
    assign ld_idx  = word_idx(ld_addr);

    always_comb begin
        r_state_nxt = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_state_nxt = R_DATA;
            R_DATA:  if (r_hs && r_final) r_state_nxt = R_IDLE;
            default: r_state_nxt = R_IDLE;
        endcase
    end

    // rdata is a registered read, so a same-edge write leaves the old word here
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_addr  <= '0;
            r_size  <= '0;
            r_burst <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_berr  <= 1'b0;
            rdata   <= '0;
            rresp   <= RESP_OKAY;
        end else begin
            if (ar_hs) begin
                r_size  <= arsize;
                r_burst <= arburst;
                r_len   <= arlen;
                r_cnt   <= '0;
                r_berr  <= ld_berr;
            end else if (r_hs) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (r_load) begin
                r_addr <= ld_addr;
                rresp  <= ld_resp;
                rdata  <= (ld_resp == RESP_OKAY) ? mem[ld_idx] : '0;
            end
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_state_nxt;
            r_state <= r_state_nxt;
        end
    end

endmodule
